// File: rtl/traffic_input_conditioner_if.sv
// Link between the input conditioner and the traffic-light controller.
// Latency: none, wires only.
// Backpressure: none; walkAck and tickRestart are single-cycle pulses from the controller.
//
// master: conditioner side (drives walkReq/Sensor/tick, receives walkAck/tickRestart)
// slave : controller side
interface traffic_input_conditioner_if;
    logic walkAck;
    logic tickRestart;
    logic walkReq;
    logic Sensor;
    logic tick;

    modport master (
        input  walkAck,
        input  tickRestart,
        output walkReq,
        output Sensor,
        output tick
    );

    modport slave (
        output walkAck,
        output tickRestart,
        input  walkReq,
        input  Sensor,
        input  tick
    );
endinterface

// File: rtl/traffic_input_conditioner.sv
// Synchronizes and debounces the walk button and the vehicle sensor, holds a sticky walk request, and generates the timing tick.
// Latency: a raw level reaches the debounced level DEBOUNCE_CYCLES+1 edges after it is first sampled; walkReq follows one edge later.
// Backpressure: none; walkReq stays set until walkAck, and tickRestart re-phases the tick counter.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   walkButtonRaw   raw pedestrian button (asynchronous, bouncing)
//   sensorRaw       raw side-street sensor (asynchronous, bouncing)
//   ctl             controller link: walkAck/tickRestart in, walkReq/Sensor/tick out
module traffic_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic walkButtonRaw,
    input  logic sensorRaw,
    traffic_input_conditioner_if.master ctl
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    // Channel 0 is the walk button, channel 1 is the vehicle sensor.
    logic [1:0]    rawIn;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    dbLvl;
    logic [DW-1:0] dbCnt [2];

    logic          walkLvlPrev;
    logic          walkReqQ;
    logic          walkRise;

    logic [TW-1:0] tickCnt;
    logic          tickQ;

    assign rawIn = {sensorRaw, walkButtonRaw};

    // Two-flop synchronizers followed by independent debouncers. A level is
    // accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles;
    // any matching cycle throws the partial count away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            dbLvl <= '0;
            for (int i = 0; i < 2; i++) begin
                dbCnt[i] <= '0;
            end
        end else begin
            sync1 <= rawIn;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == dbLvl[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DB_LAST) begin
                    dbLvl[i] <= sync2[i];
                    dbCnt[i] <= '0;
                end else begin
                    dbCnt[i] <= dbCnt[i] + DW'(1);
                end
            end
        end
    end

    // Only a fresh 0->1 of the debounced button sets the request, so a held
    // button cannot re-arm it after an ack. Set beats a coincident ack.
    assign walkRise = dbLvl[0] & ~walkLvlPrev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            walkLvlPrev <= 1'b0;
            walkReqQ    <= 1'b0;
        end else begin
            walkLvlPrev <= dbLvl[0];
            if (walkRise) begin
                walkReqQ <= 1'b1;
            end else if (ctl.walkAck) begin
                walkReqQ <= 1'b0;
            end
        end
    end

    // Tick counter wraps at TICK_LAST and pulses tick on the wrap edge.
    // A restart reloads zero and swallows any tick due on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tickCnt <= '0;
            tickQ   <= 1'b0;
        end else if (ctl.tickRestart) begin
            tickCnt <= '0;
            tickQ   <= 1'b0;
        end else if (tickCnt == TICK_LAST) begin
            tickCnt <= '0;
            tickQ   <= 1'b1;
        end else begin
            tickCnt <= tickCnt + TW'(1);
            tickQ   <= 1'b0;
        end
    end

    assign ctl.walkReq = walkReqQ;
    assign ctl.Sensor  = dbLvl[1];
    assign ctl.tick    = tickQ;
endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Bench for traffic_input_conditioner with DEBOUNCE_CYCLES=4, TICK_CYCLES=10.
// Inputs are driven on the falling edge; outputs are compared on the falling edge.
// A directed vector table, a randomized phase against a reference model, and a mid-cycle reset sequence.
module tb_traffic_input_conditioner;
    localparam int DB = 4;
    localparam int TK = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic walkButtonRaw = 1'b0;
    logic sensorRaw = 1'b0;

    traffic_input_conditioner_if ifc ();

    traffic_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .TICK_CYCLES     (TK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .walkButtonRaw (walkButtonRaw),
        .sensorRaw     (sensorRaw),
        .ctl           (ifc.master)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErr = 0;

    task automatic check(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Reference model. A level is accepted once the synchronized input
    // (raw delayed by two edges) has disagreed with it for DB cycles in a row;
    // the tick fires every TK-th edge counted from reset or the last restart.
    bit sensHist[$];
    bit walkHist[$];
    bit mSens, mWalkLvl, mRose, mReq, mTick;
    int sinceStart;

    // At an edge, h[0] is the raw sample from the previous edge; h[1..DB] are
    // the synchronized values seen during the last DB cycles.
    function automatic bit allDiffer(input bit h[$], input bit lvl);
        for (int k = 1; k <= DB; k++) begin
            if (h[k] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit sFlip, wFlip;
        if (!rst) begin
            sensHist = {};
            walkHist = {};
            for (int k = 0; k <= DB; k++) begin
                sensHist.push_back(1'b0);
                walkHist.push_back(1'b0);
            end
            mSens = 0; mWalkLvl = 0; mRose = 0; mReq = 0; mTick = 0;
            sinceStart = 0;
        end else begin
            sFlip = allDiffer(sensHist, mSens);
            wFlip = allDiffer(walkHist, mWalkLvl);
            if (mRose) mReq = 1'b1;
            else if (ifc.walkAck) mReq = 1'b0;
            mRose = wFlip && !mWalkLvl;
            if (sFlip) mSens = !mSens;
            if (wFlip) mWalkLvl = !mWalkLvl;
            sensHist.push_front(sensorRaw);
            void'(sensHist.pop_back());
            walkHist.push_front(walkButtonRaw);
            void'(walkHist.pop_back());
            if (ifc.tickRestart) begin
                sinceStart = 0;
                mTick = 1'b0;
            end else begin
                sinceStart++;
                mTick = (sinceStart % TK) == 0;
            end
        end
    end

    bit chkEn = 0;
    always @(negedge clk) begin
        if (chkEn) begin
            check("model_walkReq", ifc.walkReq, mReq);
            check("model_Sensor", ifc.Sensor, mSens);
            check("model_tick", ifc.tick, mTick);
        end
    end

    typedef struct {
        bit walk;
        bit sens;
        bit ack;
        bit restart;
        int run;
        bit eReq;
        bit eSens;
        bit eTick;
    } vec_t;

    vec_t tbl [30];

    task automatic drive(input bit w, input bit s, input bit a, input bit r);
        walkButtonRaw = w;
        sensorRaw     = s;
        ifc.walkAck     = a;
        ifc.tickRestart = r;
    endtask

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Edge numbers in comments count rising edges after reset release.
        tbl[0]  = '{0,1,0,0,5,0,0,0}; // e5  sensor not yet accepted
        tbl[1]  = '{0,1,0,0,1,0,1,0}; // e6  sensor rises
        tbl[2]  = '{0,0,0,0,3,0,1,0}; // e9
        tbl[3]  = '{0,0,0,0,1,0,1,1}; // e10 first tick
        tbl[4]  = '{0,0,0,0,1,0,1,0}; // e11 tick one cycle wide
        tbl[5]  = '{0,0,0,0,1,0,0,0}; // e12 sensor falls
        tbl[6]  = '{1,0,0,0,1,0,0,0}; // e13 bounce
        tbl[7]  = '{0,0,0,0,1,0,0,0}; // e14
        tbl[8]  = '{1,0,0,0,1,0,0,0}; // e15
        tbl[9]  = '{0,0,0,0,1,0,0,0}; // e16
        tbl[10] = '{1,0,0,0,6,0,0,0}; // e22 level rises here
        tbl[11] = '{1,0,0,0,1,1,0,0}; // e23 walkReq set
        tbl[12] = '{0,0,0,0,3,1,0,0}; // e26 release has no effect
        tbl[13] = '{0,0,1,0,1,0,0,0}; // e27 ack clears
        tbl[14] = '{0,0,0,0,3,0,0,1}; // e30 tick
        tbl[15] = '{0,0,1,0,1,0,0,0}; // e31 ack while idle ignored
        tbl[16] = '{1,0,0,0,6,0,0,0}; // e37 level rises here
        tbl[17] = '{1,0,1,0,1,1,0,0}; // e38 set wins over ack
        tbl[18] = '{1,0,0,0,5,1,0,0}; // e43
        tbl[19] = '{1,0,1,0,1,0,0,0}; // e44 ack clears
        tbl[20] = '{1,0,0,0,3,0,0,0}; // e47 held button does not re-set
        tbl[21] = '{1,0,0,1,1,0,0,0}; // e48 restart
        tbl[22] = '{1,0,0,0,2,0,0,0}; // e50 old phase tick gone
        tbl[23] = '{1,0,0,0,7,0,0,0}; // e57
        tbl[24] = '{1,0,0,0,1,0,0,1}; // e58 tick 10 after restart
        tbl[25] = '{1,0,0,0,8,0,0,0}; // e66
        tbl[26] = '{1,0,0,0,1,0,0,0}; // e67
        tbl[27] = '{1,0,0,1,1,0,0,0}; // e68 restart swallows due tick
        tbl[28] = '{1,0,0,0,9,0,0,0}; // e77
        tbl[29] = '{1,0,0,0,1,0,0,1}; // e78

        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_walkReq", ifc.walkReq, 1'b0);
        check("reset_Sensor", ifc.Sensor, 1'b0);
        check("reset_tick", ifc.tick, 1'b0);

        // Release at a falling edge so the next rising edge is e1.
        rst = 1'b1;
        chkEn = 1;
        foreach (tbl[i]) begin
            drive(tbl[i].walk, tbl[i].sens, tbl[i].ack, tbl[i].restart);
            repeat (tbl[i].run) @(negedge clk);
            check($sformatf("vec%0d_walkReq", i), ifc.walkReq, tbl[i].eReq);
            check($sformatf("vec%0d_Sensor", i), ifc.Sensor, tbl[i].eSens);
            check($sformatf("vec%0d_tick", i), ifc.tick, tbl[i].eTick);
        end

        // Randomized phase: raw levels held for random runs so some qualify
        // and some are glitches; ack and restart pulse sporadically.
        begin
            bit w, s;
            int holdW, holdS;
            w = 0; s = 0; holdW = 0; holdS = 0;
            for (int c = 0; c < 800; c++) begin
                if (holdW == 0) begin w = ~w; holdW = $urandom_range(1, 8); end
                if (holdS == 0) begin s = ~s; holdS = $urandom_range(1, 8); end
                holdW--; holdS--;
                drive(w, s, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
                @(negedge clk);
            end
        end

        // Mid-cycle reset with walkReq set and sensor part-way qualified.
        drive(0, 0, 0, 0);
        repeat (8) @(negedge clk);
        walkButtonRaw = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_reset_walkReq", ifc.walkReq, 1'b1);
        sensorRaw = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_Sensor", ifc.Sensor, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_reset_walkReq", ifc.walkReq, 1'b0);
        check("async_reset_Sensor", ifc.Sensor, 1'b0);
        check("async_reset_tick", ifc.tick, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_e5_Sensor", ifc.Sensor, 1'b0);
        check("post_reset_e5_walkReq", ifc.walkReq, 1'b0);
        @(negedge clk);
        check("post_reset_e6_Sensor", ifc.Sensor, 1'b1);
        check("post_reset_e6_walkReq", ifc.walkReq, 1'b0);
        @(negedge clk);
        check("post_reset_e7_walkReq", ifc.walkReq, 1'b1);
        repeat (4) @(negedge clk);

        chkEn = 0;
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end
endmodule
